axi_word_writer: RTL and testbench
==================================

# axi_word_writer

Downstream consumer of the 256-bit word FIFO that the byte packer fills. Pops packed words from the word FIFO read side and writes them to DDR as fixed-length AXI4 INCR bursts into a circular address window. Reports slave write errors through a sticky flag. Sits between the word FIFO and the DDR controller AXI slave port.

## Interface
Parameters:
- WORD_WIDTH, 256, data beat width in bits; fixed at 256 (32 bytes).
- ADDR_WIDTH, 32, AXI address width.
- COUNT_WIDTH, 6, width of the word FIFO read-side occupancy count.
- BURST_LEN, 16, beats per burst (1..256); BURST_LEN*32 must divide 4096.
- BASE_ADDR, 32'h0000_0000, window start; aligned to BURST_LEN*32 bytes.
- WINDOW_BYTES, 32'h0010_0000, window size; a multiple of BURST_LEN*32.

Ports:
- clk, in, 1, single clock (word FIFO read clock and AXI clock).
- rst, in, 1, asynchronous, active-high reset.
- enable, in, 1, start new bursts while high.
- word_fifo_rd_count, in, COUNT_WIDTH, words available in the FIFO.
- word_fifo_data, in, WORD_WIDTH, FIFO read data, valid the cycle after word_fifo_rd_en.
- word_fifo_rd_en, out, 1, pop one word.
- m_axi_awaddr / awlen / awsize / awburst / awvalid, out, ADDR_WIDTH/8/3/2/1.
- m_axi_awready, in, 1.
- m_axi_wdata / wstrb / wlast / wvalid, out, WORD_WIDTH/32/1/1.
- m_axi_wready, in, 1.
- m_axi_bresp / bvalid, in, 2/1. m_axi_bready, out, 1.
- busy, out, 1, state != IDLE.
- wr_error, out, 1, sticky; set on any bresp != OKAY; cleared only by rst.
- bursts_done, out, 16, completed-burst counter (see Configuration).

## Operation
- Reset values: every output 0, except awlen = BURST_LEN-1, awsize = 3'b101, awburst = 2'b01 (constants), wstrb = all ones, and awaddr = BASE_ADDR.
- FSM states: IDLE, AW, LOAD, W, B.
- IDLE: when enable && word_fifo_rd_count >= BURST_LEN, go to AW. Starting a burst is gated on a full burst being present, so the FIFO never underflows mid-burst.
- AW: awvalid = 1, held with awaddr stable until awready. Then go to LOAD. W is never driven before AW is accepted.
- LOAD: word_fifo_rd_en = 1 for exactly one cycle (combinational decode of state). Next state is W, and word_fifo_data is captured into wdata on that edge.
- W: wvalid = 1 and wlast = (beat == BURST_LEN-1); wdata is held stable until wready.
  - On a handshake, beat increments.
  - If wlast, go to B; otherwise go to LOAD.
- B: bready = 1. On bvalid:
  - If bresp != 2'b00, set wr_error.
  - Advance awaddr by BURST_LEN*32. If the result equals BASE_ADDR+WINDOW_BYTES, wrap to BASE_ADDR.
  - Clear beat and return to IDLE.
- The burst is retired regardless of the bresp value; there is no retry.
- Deasserting enable mid-burst does not abort the burst. It only blocks the next IDLE->AW transition.
- Address arithmetic is done in ADDR_WIDTH bits; beat is 8 bits.
- Reset asserted mid-burst forces IDLE immediately. A partial AXI transaction is abandoned, so the interconnect must share the same rst.

## Timing
- Threshold met in IDLE -> awvalid high the next cycle.
- Per beat: minimum 2 cycles (LOAD + W with wready already high), so throughput is one beat per 2 cycles.
- Minimum burst: 1 (AW) + 2*BURST_LEN + 1 (B) cycles, with zero-wait ready/bvalid.
- wready held low stalls in W with no additional FIFO pop.
- bursts_done increments in the same cycle as the B handshake.

## Configuration
- AXI_WR_STATS_EN defined: bursts_done counts completed bursts; it is 16-bit and wraps at 65535 -> 0.
- AXI_WR_STATS_EN undefined: bursts_done is tied to 0 and no counter is synthesized. wr_error remains in both builds.

## Structure
- Package axi_wr_pkg holds:
  - AXI_BURST_INCR = 2'b01, AXI_SIZE_32B = 3'b101, AXI_RESP_OKAY = 2'b00.
  - The FSM state enum typedef wr_state_t.
- Sub-module word_addr_gen holds the window address register, its advance and its wrap logic. It takes advance and rst and outputs addr.

## Test plan
- BURST_LEN=4, FIFO count 3, enable=1 -> no awvalid. Count goes to 4 -> awvalid the next cycle with awaddr=BASE_ADDR, awlen=3.
- Words 0xA0..0xA3 with ready always high -> 4 W beats with matching wdata, wlast only on beat 3, 4 rd_en pulses, next awaddr=BASE+128.
- Random wready stalls of 0-5 cycles -> wdata/wvalid stable while stalled, no extra rd_en, same data order.
- WINDOW_BYTES=256, BURST_LEN=4 -> awaddr sequence BASE, BASE+128, BASE (wrap).
- bresp=2'b10 on burst 2 -> wr_error=1 and stays 1. The next burst still issues; bursts_done=3 after 3 bursts (stats build), 0 in the non-stats build.
- rst pulsed during W beat 2 -> all outputs return to reset values asynchronously. After release, a new burst starts from BASE_ADDR.

Source files
------------

// File: rtl/axi_wr_pkg.sv
// Shared AXI constants and FSM state type for the word writer.
package axi_wr_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_32B   = 3'b101;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int unsigned BYTES_PER_BEAT = 32;

    typedef enum logic [2:0] {
        StIdle,
        StAw,
        StLoad,
        StW,
        StB
    } wr_state_t;

endpackage

// File: rtl/word_addr_gen.sv
// Circular burst address register: steps by one burst per advance and wraps at the window end.
module word_addr_gen #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter logic [ADDR_WIDTH-1:0] WINDOW_BYTES = 32'h0010_0000,
    parameter logic [ADDR_WIDTH-1:0] STEP_BYTES   = 32'd512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam logic [ADDR_WIDTH-1:0] END_ADDR = BASE_ADDR + WINDOW_BYTES;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH-1:0] addr_inc;

    always_comb begin
        addr_inc = addr_q + STEP_BYTES;
        addr_d   = addr_q;
        if (advance) begin
            addr_d = (addr_inc == END_ADDR) ? BASE_ADDR : addr_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= BASE_ADDR;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/axi_word_writer.sv
// Drains the packed-word FIFO into fixed-length AXI4 INCR write bursts over a circular window.
// Define AXI_WR_STATS_EN to build the completed-burst counter on bursts_done.
module axi_word_writer
    import axi_wr_pkg::*;
#(
    parameter int unsigned           WORD_WIDTH   = 256,
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           COUNT_WIDTH  = 6,
    parameter int unsigned           BURST_LEN    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] WINDOW_BYTES = 32'h0010_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [COUNT_WIDTH-1:0]  word_fifo_rd_count,
    input  logic [WORD_WIDTH-1:0]   word_fifo_data,
    output logic                    word_fifo_rd_en,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [WORD_WIDTH-1:0]   m_axi_wdata,
    output logic [WORD_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic                    busy,
    output logic                    wr_error,
    output logic [15:0]             bursts_done
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP_BYTES = ADDR_WIDTH'(BURST_LEN * BYTES_PER_BEAT);

    wr_state_t             state_q, state_d;
    logic [7:0]            beat_q, beat_d;
    logic                  wr_error_q;
    logic                  load_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic                  advance;
    logic                  burst_ready;
    logic                  last_beat;

    assign burst_ready = 32'(word_fifo_rd_count) >= BURST_LEN;
    assign last_beat   = (beat_q == LAST_BEAT);

    word_addr_gen #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .BASE_ADDR    (BASE_ADDR),
        .WINDOW_BYTES (WINDOW_BYTES),
        .STEP_BYTES   (STEP_BYTES)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .addr    (m_axi_awaddr)
    );

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        m_axi_awvalid   = 1'b0;
        word_fifo_rd_en = 1'b0;
        m_axi_wvalid    = 1'b0;
        m_axi_wlast     = 1'b0;
        m_axi_bready    = 1'b0;
        advance         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && burst_ready) begin
                    state_d = StAw;
                end
            end
            StAw: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                word_fifo_rd_en = 1'b1;
                state_d         = StW;
            end
            StW: begin
                m_axi_wvalid = 1'b1;
                m_axi_wlast  = last_beat;
                if (m_axi_wready) begin
                    beat_d  = beat_q + 8'd1;
                    state_d = last_beat ? StB : StLoad;
                end
            end
            StB: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    advance = 1'b1;
                    beat_d  = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            wr_error_q <= 1'b0;
            load_q     <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            load_q  <= (state_q == StLoad);
            if (load_q) begin
                wdata_q <= word_fifo_data;
            end
            if (advance && (m_axi_bresp != AXI_RESP_OKAY)) begin
                wr_error_q <= 1'b1;
            end
        end
    end

    // FIFO read data lands the cycle after the pop, so the first W cycle forwards it directly
    // and the hold register keeps the beat stable through any wready stall.
    assign m_axi_wdata = load_q ? word_fifo_data : wdata_q;

    assign m_axi_awlen   = LAST_BEAT;
    assign m_axi_awsize  = AXI_SIZE_32B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wstrb   = '1;
    assign busy          = (state_q != StIdle);
    assign wr_error      = wr_error_q;

`ifdef AXI_WR_STATS_EN
    logic [15:0] bursts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bursts_q <= '0;
        end else if (advance) begin
            bursts_q <= bursts_q + 16'd1;
        end
    end

    assign bursts_done = bursts_q;
`else
    assign bursts_done = '0;
`endif

endmodule

// File: tb/tb_axi_word_writer.sv
// Scoreboard bench for axi_word_writer with a FIFO model and a simple AXI write slave.
module tb_axi_word_writer;

    localparam int unsigned BL   = 4;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] WIN  = 32'd256;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [5:0]   word_fifo_rd_count;
    logic [255:0] word_fifo_data;
    logic         word_fifo_rd_en;
    logic [31:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_awvalid;
    logic         m_axi_awready;
    logic [255:0] m_axi_wdata;
    logic [31:0]  m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready;
    logic [1:0]   m_axi_bresp;
    logic         m_axi_bvalid;
    logic         m_axi_bready;
    logic         busy;
    logic         wr_error;
    logic [15:0]  bursts_done;

    axi_word_writer #(
        .WORD_WIDTH   (256),
        .ADDR_WIDTH   (32),
        .COUNT_WIDTH  (6),
        .BURST_LEN    (BL),
        .BASE_ADDR    (BASE),
        .WINDOW_BYTES (WIN)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .word_fifo_rd_count (word_fifo_rd_count),
        .word_fifo_data     (word_fifo_data),
        .word_fifo_rd_en    (word_fifo_rd_en),
        .m_axi_awaddr       (m_axi_awaddr),
        .m_axi_awlen        (m_axi_awlen),
        .m_axi_awsize       (m_axi_awsize),
        .m_axi_awburst      (m_axi_awburst),
        .m_axi_awvalid      (m_axi_awvalid),
        .m_axi_awready      (m_axi_awready),
        .m_axi_wdata        (m_axi_wdata),
        .m_axi_wstrb        (m_axi_wstrb),
        .m_axi_wlast        (m_axi_wlast),
        .m_axi_wvalid       (m_axi_wvalid),
        .m_axi_wready       (m_axi_wready),
        .m_axi_bresp        (m_axi_bresp),
        .m_axi_bvalid       (m_axi_bvalid),
        .m_axi_bready       (m_axi_bready),
        .busy               (busy),
        .wr_error           (wr_error),
        .bursts_done        (bursts_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] fifo_q[$];
    logic [255:0] exp_data_q[$];
    logic [31:0]  exp_addr_q[$];
    logic [1:0]   resp_q[$];

    logic         pop_pending = 1'b0;
    logic         b_pending   = 1'b0;
    logic         b_seen      = 1'b0;
    logic         bd_check    = 1'b0;
    logic         stall_prev  = 1'b0;
    logic [255:0] stall_data  = '0;
    logic         stall_mode  = 1'b0;
    int           stall_cnt   = 0;
    int           beat_tb     = 0;
    int           rd_burst    = 0;
    int           b_total     = 0;
    int           bursts_exp  = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [255:0] w);
        fifo_q.push_back(w);
        exp_data_q.push_back(w);
        word_fifo_rd_count = 6'(fifo_q.size());
    endtask

    task automatic wait_bursts(input int n);
        int cyc;
        cyc = 0;
        while (b_total < n && cyc < 300) begin
            @(posedge clk);
            cyc++;
        end
        check_eq("burst_timeout", 256'(b_total >= n), 256'd1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: samples at negedge, ahead of the edge on which handshakes complete.
    initial begin
        logic [255:0] exp_w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stall_prev) begin
                    check_eq("stall_wvalid", 256'(m_axi_wvalid), 256'd1);
                    check_eq("stall_wdata", m_axi_wdata, stall_data);
                end
                stall_prev = m_axi_wvalid && !m_axi_wready;
                stall_data = m_axi_wdata;
                if (m_axi_wvalid) check_eq("rd_en_in_w", 256'(word_fifo_rd_en), 256'd0);
                if (m_axi_awvalid) check_eq("w_before_aw", 256'(m_axi_wvalid), 256'd0);
                if (bd_check) begin
                    check_eq("bursts_done", 256'(bursts_done), 256'(bursts_exp));
                    bd_check = 1'b0;
                end
                if (word_fifo_rd_en) begin
                    pop_pending = 1'b1;
                    rd_burst++;
                end
                if (m_axi_awvalid && m_axi_awready) begin
                    if (exp_addr_q.size() == 0) begin
                        check_eq("aw_unexpected", 256'd1, 256'd0);
                    end else begin
                        check_eq("awaddr", 256'(m_axi_awaddr), 256'(exp_addr_q.pop_front()));
                    end
                    check_eq("awlen", 256'(m_axi_awlen), 256'(BL - 1));
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    if (exp_data_q.size() == 0) begin
                        check_eq("w_unexpected", 256'd1, 256'd0);
                    end else begin
                        exp_w = exp_data_q.pop_front();
                        check_eq("wdata", m_axi_wdata, exp_w);
                    end
                    check_eq("wlast", 256'(m_axi_wlast), 256'(beat_tb == BL - 1));
                    beat_tb = (beat_tb == BL - 1) ? 0 : beat_tb + 1;
                    if (m_axi_wlast) begin
                        b_pending = 1'b1;
                        check_eq("rd_en_pulses", 256'(rd_burst), 256'(BL));
                        rd_burst = 0;
                    end
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    b_seen = 1'b1;
                    b_total++;
`ifdef AXI_WR_STATS_EN
                    bursts_exp++;
`endif
                    bd_check = 1'b1;
                end
            end
        end
    end

    // FIFO read side and AXI slave, driven just after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (pop_pending) begin
                    if (fifo_q.size() == 0) begin
                        check_eq("fifo_underflow", 256'd1, 256'd0);
                    end else begin
                        word_fifo_data = fifo_q.pop_front();
                    end
                    pop_pending = 1'b0;
                end
                word_fifo_rd_count = 6'(fifo_q.size());
                if (stall_cnt != 0) begin
                    m_axi_wready = 1'b0;
                    stall_cnt--;
                end else begin
                    m_axi_wready = 1'b1;
                    if (stall_mode) stall_cnt = int'($urandom_range(0, 5));
                end
                m_axi_awready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                if (b_seen) begin
                    m_axi_bvalid = 1'b0;
                    m_axi_bresp  = 2'b00;
                    b_seen       = 1'b0;
                end
                if (b_pending) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
                    b_pending    = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [255:0] w;
        int           cyc;
        rst                = 1'b1;
        enable             = 1'b0;
        word_fifo_rd_count = '0;
        word_fifo_data     = '0;
        m_axi_awready      = 1'b0;
        m_axi_wready       = 1'b0;
        m_axi_bresp        = 2'b00;
        m_axi_bvalid       = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_awaddr", 256'(m_axi_awaddr), 256'(BASE));
        check_eq("rst_awlen", 256'(m_axi_awlen), 256'd3);
        check_eq("rst_awsize", 256'(m_axi_awsize), 256'd5);
        check_eq("rst_awburst", 256'(m_axi_awburst), 256'd1);
        check_eq("rst_wstrb", 256'(m_axi_wstrb), 256'hFFFF_FFFF);
        check_eq("rst_ctrl", 256'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                                   word_fifo_rd_en, busy, wr_error}), 256'd0);
        check_eq("rst_wdata", m_axi_wdata, 256'd0);
        check_eq("rst_bursts", 256'(bursts_done), 256'd0);

        @(posedge clk);
        #2 rst = 1'b0;
        enable = 1'b1;

        // Burst 1: threshold gating, then data A0..A3 with ready held high.
        exp_addr_q.push_back(BASE);
        push_word(256'hA0);
        push_word(256'hA1);
        push_word(256'hA2);
        repeat (5) begin
            @(negedge clk);
            check_eq("aw_gated", 256'({m_axi_awvalid, busy}), 256'd0);
        end
        @(posedge clk);
        #2 push_word(256'hA3);
        @(negedge clk);
        check_eq("aw_gated_still", 256'(m_axi_awvalid), 256'd0);
        @(negedge clk);
        check_eq("aw_start", 256'(m_axi_awvalid), 256'd1);
        check_eq("aw_start_addr", 256'(m_axi_awaddr), 256'(BASE));
        wait_bursts(1);
        check_eq("addr_next", 256'(m_axi_awaddr), 256'(BASE + 32'd128));
        check_eq("err_after_1", 256'(wr_error), 256'd0);

        // Burst 2: random wready/awready stalls and a SLVERR response.
        stall_mode = 1'b1;
        resp_q.push_back(2'b10);
        exp_addr_q.push_back(BASE + 32'd128);
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) push_word(256'hB0 + 256'(i));
        wait_bursts(2);
        check_eq("err_set", 256'(wr_error), 256'd1);
        check_eq("addr_wrap", 256'(m_axi_awaddr), 256'(BASE));

        // Burst 3: wrapped address, random data, error stays sticky.
        stall_mode = 1'b0;
        exp_addr_q.push_back(BASE);
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            w = '0;
            for (int j = 0; j < 8; j++) w = {w[223:0], 32'($urandom)};
            push_word(w);
        end
        wait_bursts(3);
        check_eq("err_sticky", 256'(wr_error), 256'd1);
        check_eq("addr_after_3", 256'(m_axi_awaddr), 256'(BASE + 32'd128));
`ifdef AXI_WR_STATS_EN
        check_eq("bursts_3", 256'(bursts_done), 256'd3);
`else
        check_eq("bursts_3", 256'(bursts_done), 256'd0);
`endif
        check_eq("sb_empty", 256'(exp_data_q.size()), 256'd0);

        // Enable low blocks new bursts even with a full burst waiting.
        enable = 1'b0;
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) push_word(256'hD0 + 256'(i));
        repeat (8) @(negedge clk);
        check_eq("enable_low", 256'({m_axi_awvalid, busy}), 256'd0);

        // Reset asserted while beat 2 is presented.
        exp_addr_q.push_back(BASE + 32'd128);
        @(posedge clk);
        #2 enable = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #3;
            if (beat_tb == 2 && m_axi_wvalid) break;
            cyc++;
        end
        check_eq("beat2_timeout", 256'(cyc < 100), 256'd1);
        rst = 1'b1;
        #1;
        check_eq("arst_ctrl", 256'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                                    word_fifo_rd_en, busy, wr_error}), 256'd0);
        check_eq("arst_awaddr", 256'(m_axi_awaddr), 256'(BASE));
        check_eq("arst_bursts", 256'(bursts_done), 256'd0);
        check_eq("arst_wdata", m_axi_wdata, 256'd0);
        fifo_q.delete();
        exp_data_q.delete();
        exp_addr_q.delete();
        resp_q.delete();
        word_fifo_rd_count = '0;
        m_axi_bvalid = 1'b0;
        pop_pending  = 1'b0;
        b_pending    = 1'b0;
        b_seen       = 1'b0;
        bd_check     = 1'b0;
        stall_prev   = 1'b0;
        beat_tb      = 0;
        rd_burst     = 0;
        b_total      = 0;
        bursts_exp   = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        exp_addr_q.push_back(BASE);
        for (int i = 0; i < 4; i++) push_word(256'hE0 + 256'(i));
        wait_bursts(1);
        check_eq("post_rst_addr", 256'(m_axi_awaddr), 256'(BASE + 32'd128));
        check_eq("post_rst_err", 256'(wr_error), 256'd0);
`ifdef AXI_WR_STATS_EN
        check_eq("post_rst_bursts", 256'(bursts_done), 256'd1);
`else
        check_eq("post_rst_bursts", 256'(bursts_done), 256'd0);
`endif
        check_eq("post_rst_sb", 256'(exp_data_q.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
